fp16_divider: RTL
=================

FP16_DIVIDER -- requirements
Module: fp16_divider

Interface
REQ-001 SHALL have no parameters; all widths are fixed for IEEE-754 binary16.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RESETn  input  1  asynchronous, active-low reset.
REQ-004 A  input  16  dividend, binary16 {sign, exp[4:0], frac[9:0]}.
REQ-005 B  input  16  divisor, same format as A.
REQ-006 in_valid  input  1  A and B are valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 out  output  16  quotient A/B, binary16.
REQ-009 dz  output  1  divide-by-zero flag qualified by out_valid: B zero, A finite non-zero.
REQ-010 out_valid  output  1  out and dz hold a result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-012 SHALL implement states IDLE, DIV, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL accept operands on an edge with in_valid=1 in IDLE, capture A and B, and move to DIV.
REQ-014 SHALL ignore in_valid outside IDLE; captured operands SHALL NOT change until the next accept.
REQ-015 Sign SHALL be A[15]^B[15] for every result, including NaN, inf and zero.
REQ-016 Exponent of 0 SHALL flush the operand to zero; subnormal fraction bits are ignored.
REQ-017 Mantissas SHALL be ma={1,A[9:0]} and mb={1,B[9:0]}, 11 bits each.
REQ-018 DIV SHALL run restoring division, one quotient bit per cycle, for exactly 13 cycles.
REQ-019 Division SHALL use a 12-bit remainder initialised to ma.
REQ-020 Each DIV step: if rem>=mb then qbit=1 and rem=rem-mb, else qbit=0; then rem shifts left by 1.
REQ-021 The quotient bits SHALL be q[12:0], MSB first; q[12] carries weight 2^0.
REQ-022 Exponent SHALL be held as a 7-bit signed value e = EA - EB + 15.
REQ-023 If q[12]=1: frac=q[11:2], guard=q[1], sticky=q[0] | (rem!=0).
REQ-024 If q[12]=0: frac=q[10:1], guard=q[0], sticky=(rem!=0), and e=e-1.
REQ-025 ROUND SHALL apply round-to-nearest-even: increment frac when guard & (sticky | frac[0]).
REQ-026 If the rounding increment overflows frac, frac SHALL become 0 and e SHALL become e+1.
REQ-027 After rounding, e>=31 SHALL give magnitude 0x7C00 (infinity).
REQ-028 After rounding, e<=0 SHALL give magnitude 0x0000; the result is flushed, never subnormal.
REQ-029 Special cases SHALL be applied in this priority order:
  - NaN: A or B is NaN, 0/0, or inf/inf -> magnitude 0x7C01.
  - Infinity: A is inf, or B is zero -> magnitude 0x7C00.
  - Zero: A is zero, or B is inf -> magnitude 0x0000.
REQ-030 Special cases SHALL take the same path and latency as normal operands; the DIV result is discarded.
REQ-031 dz SHALL be 1 only when B is zero and A is finite and non-zero.
REQ-032 ROUND SHALL last 1 cycle and load out and dz; the state then moves to DONE with out_valid=1.
REQ-033 Latency SHALL be fixed: out_valid rises on the 15th rising edge after the accepting edge.
REQ-034 In DONE, out, dz and out_valid SHALL hold until a cycle with out_ready=1.
REQ-035 On the edge after the out_ready=1 cycle, out_valid SHALL drop and the state SHALL return to IDLE.
REQ-036 in_ready SHALL stay 0 in the DONE cycle that completes the output handshake; there is no accept in that cycle.
REQ-037 out_ready SHALL have no effect outside DONE.

Reset
REQ-038 RESETn=0 SHALL immediately force state=IDLE and out=0x0000, dz=0, out_valid=0, in_ready=1.
REQ-039 RESETn=0 SHALL clear the quotient, remainder and exponent registers, independent of CLK.
REQ-040 Reset during DIV or ROUND SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-041 After RESETn returns to 1, the block SHALL accept new operands on the first edge with in_valid=1.

Verification
REQ-042 Basic results, out_ready=1 throughout:
  - 0x3C00/0x3C00 -> out=0x3C00, dz=0, out_valid exactly 15 edges after the accept.
  - 0x4600/0x4000 -> 0x4200.
  - 0xC600/0x4000 -> 0xC200.
REQ-043 Rounding: 0x3C00/0x4200 (1/3) -> 0x3555.
REQ-044 Special values:
  - 0x3C00/0x0000 -> 0x7C00 with dz=1.
  - 0x0000/0x0000 -> 0x7C01 with dz=0.
  - 0x7C00/0x7C00 -> 0x7C01.
  - 0x4000/0x7C00 -> 0x0000.
REQ-045 Range limits:
  - 0x7BFF/0x0400 -> 0x7C00 (overflow).
  - 0x0400/0x7BFF -> 0x0000 (underflow flush).
REQ-046 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out stable and in_ready=0 throughout, extra in_valid ignored; then assert out_ready -> IDLE next edge.
REQ-047 Pulse RESETn=0 mid-DIV -> outputs reset immediately and no result emitted; then 0x4000/0x3C00 -> 0x4000 after 15 edges.

Source files
------------

// File: rtl/fp16_divider.sv
// Iterative IEEE-754 binary16 divider: restoring division, round-to-nearest-even, no subnormals.
// Latency: fixed, out_valid rises 15 clock edges after the accepting edge (1 setup + 13 DIV + 1 ROUND).
// Backpressure: in_ready only in IDLE; result holds in DONE until out_ready, then returns to IDLE.
//
// Ports:
//   CLK, RESETn           clock, asynchronous active-low reset
//   A, B, in_valid        dividend/divisor binary16 and their qualifier; in_ready = idle
//   out, dz, out_valid    quotient, divide-by-zero flag and their qualifier; out_ready = consumer accept
module fp16_divider (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out,
    output logic        dz,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, b_q;
    logic [3:0]         cnt_q;
    logic [11:0]        rem_q;
    logic [12:0]        quo_q;
    logic signed [6:0]  exp_q;
    logic [15:0]        out_q;
    logic               dz_q;

    // Operand fields of the captured pair
    logic [4:0]  ea, eb;
    logic [10:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a_q[14:10];
    assign eb     = b_q[14:10];
    assign ma     = {1'b1, a_q[9:0]};
    assign mb     = {1'b1, b_q[9:0]};
    // Exponent 0 means zero: subnormal fraction bits are deliberately ignored
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'd31) && (a_q[9:0] == 10'd0);
    assign b_inf  = (eb == 5'd31) && (b_q[9:0] == 10'd0);
    assign a_nan  = (ea == 5'd31) && (a_q[9:0] != 10'd0);
    assign b_nan  = (eb == 5'd31) && (b_q[9:0] != 10'd0);

    // One restoring-division step
    logic        step_ge;
    logic [11:0] rem_sub;
    assign step_ge = (rem_q >= {1'b0, mb});
    assign rem_sub = step_ge ? (rem_q - {1'b0, mb}) : rem_q;

    // Normalise, round and pack
    logic [9:0]        frac_t;
    logic              guard, sticky, inc;
    logic signed [6:0] e_n, e_r;
    logic [10:0]       fsum;
    logic [14:0]       mag;
    logic [15:0]       res;
    logic              res_dz;

    always_comb begin
        frac_t = quo_q[10:1];
        guard  = quo_q[0];
        sticky = (rem_q != 12'd0);
        e_n    = exp_q - 7'sd1;
        if (quo_q[12]) begin
            frac_t = quo_q[11:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 12'd0);
            e_n    = exp_q;
        end
        inc  = guard & (sticky | frac_t[0]);
        // A carry out of the fraction leaves fsum[9:0] at zero, which is the wanted fraction
        fsum = {1'b0, frac_t} + {10'd0, inc};
        e_r  = fsum[10] ? (e_n + 7'sd1) : e_n;

        if (e_r >= 7'sd31) begin
            mag = 15'h7C00;
        end else if (e_r <= 7'sd0) begin
            mag = 15'h0000;
        end else begin
            mag = {e_r[4:0], fsum[9:0]};
        end

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            mag = 15'h7C01;
        end else if (a_inf || b_zero) begin
            mag = 15'h7C00;
        end else if (a_zero || b_inf) begin
            mag = 15'h0000;
        end
        res    = {a_q[15] ^ b_q[15], mag};
        res_dz = b_zero && !a_zero && !a_inf && !a_nan;
    end

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = DIV;
            DIV:     if (cnt_q == 4'd13) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: DIV count 0 unpacks the operands, counts 1..13 each produce one quotient bit
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
            cnt_q <= 4'd0;
            rem_q <= 12'd0;
            quo_q <= 13'd0;
            exp_q <= 7'sd0;
            out_q <= 16'h0000;
            dz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        cnt_q <= 4'd0;
                    end
                end
                DIV: begin
                    if (cnt_q == 4'd0) begin
                        rem_q <= {1'b0, ma};
                        quo_q <= 13'd0;
                        exp_q <= 7'(ea) - 7'(eb) + 7'sd15;
                    end else begin
                        rem_q <= rem_sub << 1;
                        quo_q <= {quo_q[11:0], step_ge};
                    end
                    cnt_q <= (cnt_q == 4'd13) ? 4'd0 : cnt_q + 4'd1;
                end
                ROUND: begin
                    out_q <= res;
                    dz_q  <= res_dz;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign dz        = dz_q;

endmodule
